// File: rtl/crypto_job_sched.sv
// crypto_job_sched: in-order job FIFO feeding three crypto engines (H/E/D),
// per-engine run/timeout tracking with sticky interrupts, and a registered
// round-robin arbiter for the engines' shared buffer-memory port.
module crypto_job_sched #(
    parameter int IDX_W   = 11,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    input  logic [1:0]               cmd_eng,
    input  logic [IDX_W-1:0]         cmd_index,
    output logic                     cmd_ready,
    output logic                     cmd_err,
    output logic                     H_start,
    output logic                     E_start,
    output logic                     D_start,
    output logic [IDX_W-1:0]         H_index,
    output logic [IDX_W-1:0]         E_index,
    output logic [IDX_W-1:0]         D_index,
    input  logic                     H_done,
    input  logic                     E_done,
    input  logic                     D_done,
    output logic                     H_int,
    output logic                     E_int,
    output logic                     D_int,
    input  logic [2:0]               int_ack,
    output logic [2:0]               busy,
    output logic [2:0]               timeout_err,
    output logic [$clog2(DEPTH):0]   fifo_count,
    input  logic [2:0]               mem_req,
    output logic [2:0]               mem_gnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT) + 1;

    typedef enum logic {S_IDLE, S_RUN} eng_state_e;

    typedef struct packed {
        logic [1:0]       eng;
        logic [IDX_W-1:0] index;
    } job_t;

    // ---------------- command FIFO ----------------
    job_t             fifo_mem [DEPTH];
    job_t             push_job;
    job_t             head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             cmd_err_q, cmd_err_d;
    logic             accept, push, pop;
    logic [3:0]       idle_vec;

    assign cmd_ready  = (count_q != CNT_W'(DEPTH));
    assign fifo_count = count_q;
    assign cmd_err    = cmd_err_q;
    assign accept     = cmd_valid && cmd_ready;
    assign push       = accept && (cmd_eng != 2'd3);
    assign push_job   = '{eng: cmd_eng, index: cmd_index};
    assign head       = fifo_mem[rd_ptr_q];
    // Pop only against registered occupancy: a job pushed this cycle cannot
    // dispatch until the next edge.
    assign pop        = (count_q != '0) && idle_vec[head.eng];
    assign idle_vec[3] = 1'b0;

    // FIFO pointer, occupancy and illegal-command pulse next-state
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        cmd_err_d = accept && (cmd_eng == 2'd3);
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO control registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; pointers and count define validity, so stale entries are never read.
        if (push) fifo_mem[wr_ptr_q] <= push_job;
    end

    // ---------------- per-engine run/timeout tracking ----------------
    logic [2:0]       done_vec;
    logic [2:0]       start_vec;
    logic [2:0]       int_vec;
    logic [IDX_W-1:0] index_vec [3];

    assign done_vec = {D_done, E_done, H_done};

    for (genvar g = 0; g < 3; g++) begin : g_eng
        eng_state_e       state_q, state_d;
        logic [TO_W-1:0]  cnt_q, cnt_d;
        logic [IDX_W-1:0] index_q, index_d;
        logic             start_q, start_d;
        logic             int_q, int_d;
        logic             tmo_q, tmo_d;
        logic             int_set, tmo_set;
        logic             sel;

        assign sel = pop && (head.eng == 2'(g));

        // Engine FSM next-state, dispatch capture and sticky flag update (set beats ack)
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            index_d = index_q;
            start_d = 1'b0;
            int_set = 1'b0;
            tmo_set = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sel) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        index_d = head.index;
                        start_d = 1'b1;
                    end
                end
                S_RUN: begin
                    if (done_vec[g]) begin
                        state_d = S_IDLE;
                        int_set = 1'b1;
                    end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                        state_d = S_IDLE;
                        tmo_set = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            int_d = (int_q & ~int_ack[g]) | int_set;
            tmo_d = (tmo_q & ~int_ack[g]) | tmo_set;
        end

        // Engine state registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                index_q <= '0;
                start_q <= 1'b0;
                int_q   <= 1'b0;
                tmo_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                index_q <= index_d;
                start_q <= start_d;
                int_q   <= int_d;
                tmo_q   <= tmo_d;
            end
        end

        assign idle_vec[g]    = (state_q == S_IDLE);
        assign busy[g]        = (state_q == S_RUN);
        assign start_vec[g]   = start_q;
        assign int_vec[g]     = int_q;
        assign timeout_err[g] = tmo_q;
        assign index_vec[g]   = index_q;
    end

    assign H_start = start_vec[0];
    assign E_start = start_vec[1];
    assign D_start = start_vec[2];
    assign H_index = index_vec[0];
    assign E_index = index_vec[1];
    assign D_index = index_vec[2];
    assign H_int   = int_vec[0];
    assign E_int   = int_vec[1];
    assign D_int   = int_vec[2];

    // ---------------- shared memory port arbiter ----------------
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cand;
    logic       found;

    assign mem_gnt = gnt_q;

    // Hold the owner while it requests; otherwise grant the first requester after the last owner
    always_comb begin
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        cand  = '0;
        found = 1'b0;
        if ((gnt_q & mem_req) == 3'b000) begin
            gnt_d = 3'b000;
            for (int k = 1; k <= 3; k++) begin
                cand = 2'((int'(ptr_q) + k) % 3);
                if (!found && mem_req[cand]) begin
                    found       = 1'b1;
                    gnt_d[cand] = 1'b1;
                    ptr_d       = cand;
                end
            end
        end
    end

    // Arbiter registers; pointer starts at D so H has top priority after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q <= 3'b000;
            ptr_q <= 2'd2;
        end else begin
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
        end
    end

endmodule
